// File: rtl/alu_arb_ctrl.sv
// Two-requester round-robin arbiter sequencing one shared 8-bit ALU behind a single response channel.
// Optional build macro ALU_ARB_OPCHK_EN rejects opcodes 110/111 with rsp_err instead of executing them.
module alu_arb_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  input  logic [2:0]  req0_op,
  input  logic [2:0]  req1_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_src,
  output logic [7:0]  rsp_result,
  output logic        rsp_zero,
  output logic        rsp_ovf,
  output logic        rsp_err,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op);
    logic [15:0] prod;
    prod = 16'(a) * 16'(b);
    case (op)
      3'b000:  alu_f = a + b;
      3'b001:  alu_f = a - b;
      3'b010:  alu_f = a & b;
      3'b011:  alu_f = a | b;
      3'b100:  alu_f = prod[7:0];
      3'b101:  alu_f = a ^ b;
      default: alu_f = 8'h00;
    endcase
  endfunction

  // Signed-add style overflow, evaluated for every opcode on the 8-bit result.
  function automatic logic ovf_f(input logic [7:0] a, input logic [7:0] b, input logic [7:0] r);
    ovf_f = (a[7] & b[7] & ~r[7]) | (~a[7] & ~b[7] & r[7]);
  endfunction

  state_t      state_q;
  logic        last_grant_q;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [2:0]  op_q;
  logic        src_q;
  logic        rsp_valid_q;
  logic        rsp_src_q;
  logic [7:0]  rsp_result_q;
  logic        rsp_zero_q;
  logic        rsp_ovf_q;
  logic [15:0] op_count_q;

  logic        grant_sel_d;
  logic        accept_d;
  logic [7:0]  sel_a_d;
  logic [7:0]  sel_b_d;
  logic [2:0]  sel_op_d;
  logic [7:0]  raw_res_d;
  logic [7:0]  exe_res_d;
  logic        exe_zero_d;
  logic        exe_ovf_d;

`ifdef ALU_ARB_OPCHK_EN
  logic        err_q;
  logic        rsp_err_q;
`endif

  // Round-robin pick: on a tie the requester that did not win last time is granted.
  always_comb begin
    grant_sel_d = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_sel_d = ~last_grant_q;
    end else if (req1_valid) begin
      grant_sel_d = 1'b1;
    end else begin
      grant_sel_d = 1'b0;
    end
    accept_d = (state_q == IDLE) && (req0_valid || req1_valid);
    sel_a_d  = grant_sel_d ? req1_a  : req0_a;
    sel_b_d  = grant_sel_d ? req1_b  : req0_b;
    sel_op_d = grant_sel_d ? req1_op : req0_op;
  end

  assign req0_ready = accept_d && !grant_sel_d;
  assign req1_ready = accept_d &&  grant_sel_d;

  // ALU evaluation on latched operands; illegal ops are masked to an all-zero response.
  always_comb begin
    raw_res_d  = alu_f(a_q, b_q, op_q);
    exe_res_d  = raw_res_d;
    exe_zero_d = (raw_res_d == 8'h00);
    exe_ovf_d  = ovf_f(a_q, b_q, raw_res_d);
`ifdef ALU_ARB_OPCHK_EN
    if (err_q) begin
      exe_res_d  = 8'h00;
      exe_zero_d = 1'b0;
      exe_ovf_d  = 1'b0;
    end else begin
      exe_res_d  = raw_res_d;
      exe_zero_d = (raw_res_d == 8'h00);
      exe_ovf_d  = ovf_f(a_q, b_q, raw_res_d);
    end
`endif
  end

  // Sequencer FSM with operand latches and registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      a_q          <= 8'h00;
      b_q          <= 8'h00;
      op_q         <= 3'b000;
      src_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_src_q    <= 1'b0;
      rsp_result_q <= 8'h00;
      rsp_zero_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      op_count_q   <= 16'h0000;
`ifdef ALU_ARB_OPCHK_EN
      err_q        <= 1'b0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            a_q          <= sel_a_d;
            b_q          <= sel_b_d;
            op_q         <= sel_op_d;
            src_q        <= grant_sel_d;
            last_grant_q <= grant_sel_d;
`ifdef ALU_ARB_OPCHK_EN
            err_q        <= sel_op_d[2] & sel_op_d[1];
`endif
            state_q      <= EXEC;
          end else begin
            state_q      <= IDLE;
          end
        end
        EXEC: begin
          rsp_valid_q  <= 1'b1;
          rsp_src_q    <= src_q;
          rsp_result_q <= exe_res_d;
          rsp_zero_q   <= exe_zero_d;
          rsp_ovf_q    <= exe_ovf_d;
`ifdef ALU_ARB_OPCHK_EN
          rsp_err_q    <= err_q;
`endif
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_count_q  <= op_count_q + 16'd1;
            state_q     <= IDLE;
          end else begin
            state_q     <= RESP;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_src    = rsp_src_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_ovf    = rsp_ovf_q;
  assign op_count   = op_count_q;
`ifdef ALU_ARB_OPCHK_EN
  assign rsp_err    = rsp_err_q;
`else
  assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arb_ctrl.sv
// Directed self-checking bench for alu_arb_ctrl: handshake latency, ALU ops, round-robin, stall, reset.
// Expectations for opcodes 110/111 follow the ALU_ARB_OPCHK_EN setting of the build.
module tb_alu_arb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready, rsp_src;
  logic [7:0]  rsp_result;
  logic        rsp_zero, rsp_ovf, rsp_err;
  logic [15:0] op_count;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_count = 16'd0;

  always #5 clk = ~clk;

  alu_arb_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_src(rsp_src),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf),
    .rsp_err(rsp_err), .op_count(op_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    exp_count = 16'd0;
  endtask

  task automatic test_reset();
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    req0_a = 8'h00; req0_b = 8'h00; req0_op = 3'b000;
    req1_a = 8'h00; req1_b = 8'h00; req1_op = 3'b000;
    rst_n = 1'b0;
    #3;
    n_checks++;
    if ({rsp_valid, rsp_src, rsp_result, rsp_zero, rsp_ovf, rsp_err} !== 13'h0) begin
      $display("FAIL reset_rsp: got %h want 0000", {rsp_valid, rsp_src, rsp_result, rsp_zero, rsp_ovf, rsp_err});
    end else n_pass++;
    n_checks++;
    if (op_count !== 16'h0000) $display("FAIL reset_count: got %h want 0000", op_count);
    else n_pass++;
    n_checks++;
    if ({req1_ready, req0_ready} !== 2'b00) $display("FAIL reset_ready: got %b want 00", {req1_ready, req0_ready});
    else n_pass++;
    apply_reset();
  endtask

  // One isolated operation from requester src with rsp_ready held high.
  task automatic run_single(input logic src, input logic [7:0] a, input logic [7:0] b,
                            input logic [2:0] op, input logic [7:0] er, input logic ez,
                            input logic eo, input logic ee, input string name);
    rsp_ready = 1'b1;
    if (src) begin
      req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
    end
    #1;
    n_checks++;
    if ({req1_ready, req0_ready} !== (src ? 2'b10 : 2'b01))
      $display("FAIL %s_ready: got %b want %b", name, {req1_ready, req0_ready}, (src ? 2'b10 : 2'b01));
    else n_pass++;
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0) $display("FAIL %s_exec_valid: got %b want 0", name, rsp_valid);
    else n_pass++;
    step();
    n_checks++;
    if ({rsp_valid, rsp_src, rsp_result, rsp_zero, rsp_ovf, rsp_err} !== {1'b1, src, er, ez, eo, ee})
      $display("FAIL %s_rsp: got %h want %h", name,
               {rsp_valid, rsp_src, rsp_result, rsp_zero, rsp_ovf, rsp_err}, {1'b1, src, er, ez, eo, ee});
    else n_pass++;
    step();
    exp_count = exp_count + 16'd1;
    n_checks++;
    if ({rsp_valid, op_count} !== {1'b0, exp_count})
      $display("FAIL %s_done: got valid=%b count=%h want valid=0 count=%h", name, rsp_valid, op_count, exp_count);
    else n_pass++;
  endtask

  task automatic test_alu_ops();
    run_single(1'b0, 8'h7F, 8'h01, 3'b000, 8'h80, 1'b0, 1'b1, 1'b0, "add_ovf");
    run_single(1'b1, 8'h05, 8'h05, 3'b001, 8'h00, 1'b1, 1'b0, 1'b0, "sub_zero");
    run_single(1'b1, 8'h10, 8'h10, 3'b100, 8'h00, 1'b1, 1'b0, 1'b0, "mul_low");
    run_single(1'b0, 8'hF0, 8'h3C, 3'b010, 8'h30, 1'b0, 1'b0, 1'b0, "and");
    run_single(1'b1, 8'h0F, 8'hF0, 3'b011, 8'hFF, 1'b0, 1'b0, 1'b0, "or");
    run_single(1'b0, 8'hAA, 8'hAA, 3'b101, 8'h00, 1'b1, 1'b1, 1'b0, "xor");
    run_single(1'b0, 8'h80, 8'h01, 3'b001, 8'h7F, 1'b0, 1'b0, 1'b0, "sub_wrap");
  endtask

  // The overflow formula holds for every opcode, so 0x80/0x80 with a zero result reports ovf.
  task automatic test_illegal_op();
`ifdef ALU_ARB_OPCHK_EN
    run_single(1'b0, 8'h80, 8'h80, 3'b110, 8'h00, 1'b0, 1'b0, 1'b1, "op110");
    run_single(1'b1, 8'h00, 8'h00, 3'b111, 8'h00, 1'b0, 1'b0, 1'b1, "op111");
`else
    run_single(1'b0, 8'h80, 8'h80, 3'b110, 8'h00, 1'b1, 1'b1, 1'b0, "op110");
    run_single(1'b1, 8'h00, 8'h00, 3'b111, 8'h00, 1'b1, 1'b0, 1'b0, "op111");
`endif
  endtask

  task automatic test_round_robin();
    logic g;
    apply_reset();
    req0_a = 8'h01; req0_b = 8'h02; req0_op = 3'b000;
    req1_a = 8'h09; req1_b = 8'h04; req1_op = 3'b001;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      g = k[0];
      n_checks++;
      if ({req1_ready, req0_ready} !== (g ? 2'b10 : 2'b01))
        $display("FAIL rr_grant%0d: got %b want %b", k, {req1_ready, req0_ready}, (g ? 2'b10 : 2'b01));
      else n_pass++;
      step();
      step();
      n_checks++;
      if ({rsp_valid, rsp_src, rsp_result} !== {1'b1, g, (g ? 8'h05 : 8'h03)})
        $display("FAIL rr_rsp%0d: got %h want %h", k, {rsp_valid, rsp_src, rsp_result},
                 {1'b1, g, (g ? 8'h05 : 8'h03)});
      else n_pass++;
      step();
      exp_count = exp_count + 16'd1;
      n_checks++;
      if (op_count !== exp_count) $display("FAIL rr_count%0d: got %h want %h", k, op_count, exp_count);
      else n_pass++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
  endtask

  task automatic test_stall();
    rsp_ready = 1'b0;
    req0_a = 8'h33; req0_b = 8'h11; req0_op = 3'b001; req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    step();
    req0_valid = 1'b1; req1_valid = 1'b1;
    req1_a = 8'h44; req1_b = 8'h44; req1_op = 3'b000;
    #1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({rsp_valid, rsp_src, rsp_result, rsp_zero, rsp_ovf, rsp_err, req1_ready, req0_ready, op_count}
          !== {1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 2'b00, exp_count})
        $display("FAIL stall%0d: got %h want %h", i,
                 {rsp_valid, rsp_src, rsp_result, rsp_zero, rsp_ovf, rsp_err, req1_ready, req0_ready, op_count},
                 {1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 2'b00, exp_count});
      else n_pass++;
      step();
    end
    rsp_ready = 1'b1;
    step();
    exp_count = exp_count + 16'd1;
    n_checks++;
    if ({rsp_valid, op_count, req1_ready, req0_ready} !== {1'b0, exp_count, 2'b10})
      $display("FAIL stall_release: got %h want %h", {rsp_valid, op_count, req1_ready, req0_ready},
               {1'b0, exp_count, 2'b10});
    else n_pass++;
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_exec();
    rsp_ready = 1'b1;
    req1_a = 8'h12; req1_b = 8'h34; req1_op = 3'b000; req1_valid = 1'b1;
    step();
    req1_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    exp_count = 16'd0;
    n_checks++;
    if ({rsp_valid, rsp_src, rsp_result, rsp_zero, rsp_ovf, rsp_err, op_count} !== {13'h0, exp_count})
      $display("FAIL rst_exec: got %h want %h", {rsp_valid, rsp_src, rsp_result, rsp_zero, rsp_ovf, rsp_err, op_count},
               {13'h0, exp_count});
    else n_pass++;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if ({rsp_valid, op_count} !== {1'b0, exp_count})
        $display("FAIL rst_after%0d: got valid=%b count=%h want valid=0 count=%h", i, rsp_valid, op_count, exp_count);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_illegal_op();
    test_round_robin();
    test_stall();
    test_reset_exec();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
